// File: rtl/audio_dac_serializer_if.sv
// Write-side bus of the audio DAC serializer: one left/right sample pair per
// accepted write, plus the FIFO status returned to the producer.
interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  write;
    logic [DATA_WIDTH-1:0] writedata_left;
    logic [DATA_WIDTH-1:0] writedata_right;
    logic                  write_ready;
    logic [CW-1:0]         fifo_count;

    modport master (
        output write,
        output writedata_left,
        output writedata_right,
        input  write_ready,
        input  fifo_count
    );

    modport slave (
        input  write,
        input  writedata_left,
        input  writedata_right,
        output write_ready,
        output fifo_count
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// Audio DAC serializer: buffers left/right sample pairs and shifts them out
// I2S-style (one-bit delay, MSB first) on the codec bit clock, oversampled by CLOCK_50.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  reset_n,
    audio_dac_serializer_if.slave bus,
    input  logic                  AUD_BCLK,
    input  logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT,
    output logic                  underflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LOAD_COUNT = BW'(DATA_WIDTH);

    // bclk_pipe: [0] metastable, [1] synchronized, [2] previous synchronized
    logic [2:0]            bclk_pipe_q, bclk_pipe_d;
    logic [1:0]            lrck_pipe_q, lrck_pipe_d;
    logic                  lrck_prev_q, lrck_prev_d;
    logic                  lrck_armed_q, lrck_armed_d;
    logic [DATA_WIDTH-1:0] mem_left_q  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_left_d  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_right_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_right_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] hold_left_q, hold_left_d;
    logic [DATA_WIDTH-1:0] hold_right_q, hold_right_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  dacdat_q, dacdat_d;
    logic                  underflow_q, underflow_d;

    logic bfe_s, trans_s, left_start_s, right_start_s, full_s, push_s, pop_s;

    // Nothing is flagged until the first bfe has captured a reference LRCK level
    assign bfe_s         = bclk_pipe_q[2] & ~bclk_pipe_q[1];
    assign trans_s       = bfe_s & lrck_armed_q & (lrck_pipe_q[1] != lrck_prev_q);
    assign left_start_s  = trans_s & ~lrck_pipe_q[1];
    assign right_start_s = trans_s & lrck_pipe_q[1];
    assign full_s        = (count_q == FULL_COUNT);
    assign push_s        = bus.write & ~full_s;
    assign pop_s         = left_start_s & (count_q != {CW{1'b0}});

    assign bus.write_ready = ~full_s;
    assign bus.fifo_count  = count_q;
    assign AUD_DACDAT      = dacdat_q;
    assign underflow       = underflow_q;

    // Next-state logic: synchronizers, FIFO push/pop, frame tracking and shifter
    always_comb begin
        bclk_pipe_d  = {bclk_pipe_q[1:0], AUD_BCLK};
        lrck_pipe_d  = {lrck_pipe_q[0], AUD_DACLRCK};
        lrck_prev_d  = lrck_prev_q;
        lrck_armed_d = lrck_armed_q;
        mem_left_d   = mem_left_q;
        mem_right_d  = mem_right_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        dacdat_d     = dacdat_q;
        underflow_d  = 1'b0;

        if (push_s) begin
            mem_left_d[wr_ptr_q]  = bus.writedata_left;
            mem_right_d[wr_ptr_q] = bus.writedata_right;
            wr_ptr_d              = wr_ptr_q + AW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase

        if (bfe_s) begin
            lrck_prev_d  = lrck_pipe_q[1];
            lrck_armed_d = 1'b1;
            if (left_start_s) begin
                if (pop_s) begin
                    hold_left_d  = mem_left_q[rd_ptr_q];
                    hold_right_d = mem_right_q[rd_ptr_q];
                    rd_ptr_d     = rd_ptr_q + AW'(1'b1);
                end else begin
                    hold_left_d  = {DATA_WIDTH{1'b0}};
                    hold_right_d = {DATA_WIDTH{1'b0}};
                    underflow_d  = 1'b1;
                end
                shift_d   = hold_left_d;
                bit_cnt_d = LOAD_COUNT;
            end else if (right_start_s) begin
                shift_d   = hold_right_q;
                bit_cnt_d = LOAD_COUNT;
            end else if (bit_cnt_q != {BW{1'b0}}) begin
                dacdat_d  = shift_q[DATA_WIDTH-1];
                shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - BW'(1'b1);
            end else begin
                dacdat_d = 1'b0;
            end
        end else begin
            lrck_armed_d = lrck_armed_q;
        end
    end

    // State register; reset also empties the FIFO and silences the data line
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_pipe_q  <= 3'b000;
            lrck_pipe_q  <= 2'b00;
            lrck_prev_q  <= 1'b0;
            lrck_armed_q <= 1'b0;
            mem_left_q   <= '{default: {DATA_WIDTH{1'b0}}};
            mem_right_q  <= '{default: {DATA_WIDTH{1'b0}}};
            wr_ptr_q     <= {AW{1'b0}};
            rd_ptr_q     <= {AW{1'b0}};
            count_q      <= {CW{1'b0}};
            hold_left_q  <= {DATA_WIDTH{1'b0}};
            hold_right_q <= {DATA_WIDTH{1'b0}};
            shift_q      <= {DATA_WIDTH{1'b0}};
            bit_cnt_q    <= {BW{1'b0}};
            dacdat_q     <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            bclk_pipe_q  <= bclk_pipe_d;
            lrck_pipe_q  <= lrck_pipe_d;
            lrck_prev_q  <= lrck_prev_d;
            lrck_armed_q <= lrck_armed_d;
            mem_left_q   <= mem_left_d;
            mem_right_q  <= mem_right_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            dacdat_q     <= dacdat_d;
            underflow_q  <= underflow_d;
        end
    end
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: a table of stereo frames
// plus hand-written fill, simultaneous push/pop and mid-frame reset sequences.
module tb_audio_dac_serializer;
    localparam int DW    = 24;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct {
        int            n;      // BCLKs per channel
        int            mode;   // 0 none, 1 push before frame, 2 push on the pop cycle
        logic [DW-1:0] pl;
        logic [DW-1:0] pr;
        logic [DW-1:0] el;
        logic [DW-1:0] er;
        logic [CW-1:0] ecnt;   // fifo_count just after the left frame start
        int            euf;    // underflow-high cycles during the frame
    } frame_vec_t;

    logic CLOCK_50 = 1'b0;
    logic reset_n;
    logic AUD_BCLK;
    logic AUD_DACLRCK;
    logic AUD_DACDAT;
    logic underflow;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int uf_cycles  = 0;

    frame_vec_t    vecs [10];
    logic [DW-1:0] fill_l [6];
    logic [DW-1:0] fill_r [6];

    audio_dac_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) bus_if ();

    audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .underflow   (underflow)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (underflow) uf_cycles = uf_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One BCLK period of 16 CLOCK_50 cycles; LRCK changes with the falling edge.
    task automatic bclk_pulse(input logic lrck, input logic do_push,
                              input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                              output logic bit_o, output logic [CW-1:0] cnt_o);
        @(posedge CLOCK_50);
        #5;
        AUD_BCLK    = 1'b0;
        AUD_DACLRCK = lrck;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        if (do_push) begin
            bus_if.write           = 1'b1;
            bus_if.writedata_left  = pl;
            bus_if.writedata_right = pr;
        end
        @(negedge CLOCK_50);
        bus_if.write = 1'b0;
        cnt_o = bus_if.fifo_count;
        repeat (5) @(negedge CLOCK_50);
        bit_o    = AUD_DACDAT;
        AUD_BCLK = 1'b1;
        repeat (7) @(negedge CLOCK_50);
    endtask

    task automatic run_channel(input logic lrck, input int n, input logic sp,
                               input logic [DW-1:0] pl, input logic [DW-1:0] pr,
                               output logic [DW-1:0] cap, output int nbits,
                               output logic tail_zero, output logic [CW-1:0] cnt0);
        logic          b;
        logic [CW-1:0] c;
        cap       = {DW{1'b0}};
        nbits     = 0;
        tail_zero = 1'b1;
        cnt0      = {CW{1'b0}};
        for (int k = 0; k < n; k++) begin
            bclk_pulse(lrck, sp && (k == 0), pl, pr, b, c);
            if (k == 0) cnt0 = c;
            else if (k <= DW) begin
                cap   = {cap[DW-2:0], b};
                nbits = nbits + 1;
            end else if (b) tail_zero = 1'b0;
        end
    endtask

    task automatic push_pair(input logic [DW-1:0] l, input logic [DW-1:0] r, input int exp_cnt);
        @(negedge CLOCK_50);
        bus_if.write           = 1'b1;
        bus_if.writedata_left  = l;
        bus_if.writedata_right = r;
        @(negedge CLOCK_50);
        bus_if.write = 1'b0;
        check("push_count", 32'(bus_if.fifo_count), 32'(exp_cnt));
    endtask

    task automatic run_frame(input int idx, input frame_vec_t v);
        logic [DW-1:0] cap_l, cap_r;
        int            nb_l, nb_r, uf0;
        logic          tz_l, tz_r;
        logic [CW-1:0] c_left, c_right;
        if (v.mode == 1) push_pair(v.pl, v.pr, 1);
        uf0 = uf_cycles;
        run_channel(1'b0, v.n, v.mode == 2, v.pl, v.pr, cap_l, nb_l, tz_l, c_left);
        run_channel(1'b1, v.n, 1'b0, v.pl, v.pr, cap_r, nb_r, tz_r, c_right);
        check($sformatf("frame%0d_count", idx), 32'(c_left), 32'(v.ecnt));
        check($sformatf("frame%0d_left_bits", idx), 32'(cap_l), 32'(v.el >> (DW - nb_l)));
        check($sformatf("frame%0d_right_bits", idx), 32'(cap_r), 32'(v.er >> (DW - nb_r)));
        if (v.n > DW + 1) begin
            check($sformatf("frame%0d_left_tail", idx), 32'(tz_l), 32'(1));
            check($sformatf("frame%0d_right_tail", idx), 32'(tz_r), 32'(1));
        end
        check($sformatf("frame%0d_underflow", idx), 32'(uf_cycles - uf0), 32'(v.euf));
    endtask

    initial begin
        logic          b, any;
        logic [CW-1:0] c;

        fill_l = '{24'h800001, 24'h0F0F0F, 24'h123456, 24'hFFFFFF, 24'hDEAD00, 24'h111111};
        fill_r = '{24'h7FFFFE, 24'hF0F0F0, 24'h654321, 24'h000001, 24'hBEEF00, 24'h222222};

        vecs[0] = '{32, 0, 24'h0, 24'h0, fill_l[0], fill_r[0], 3'd3, 0};
        vecs[1] = '{32, 0, 24'h0, 24'h0, fill_l[1], fill_r[1], 3'd2, 0};
        vecs[2] = '{32, 2, 24'hC3C3C3, 24'h3C3C3C, fill_l[2], fill_r[2], 3'd2, 0};
        vecs[3] = '{32, 0, 24'h0, 24'h0, fill_l[3], fill_r[3], 3'd1, 0};
        vecs[4] = '{32, 0, 24'h0, 24'h0, 24'hC3C3C3, 24'h3C3C3C, 3'd0, 0};
        vecs[5] = '{32, 0, 24'h0, 24'h0, 24'h000000, 24'h000000, 3'd0, 1};
        vecs[6] = '{16, 1, 24'hABCDEF, 24'hFEDCBA, 24'hABCDEF, 24'hFEDCBA, 3'd0, 0};
        vecs[7] = '{16, 1, 24'h13579B, 24'h2468AC, 24'h13579B, 24'h2468AC, 3'd0, 0};
        vecs[8] = '{32, 1, 24'hA5A5A5, 24'h5A5A5A, 24'hA5A5A5, 24'h5A5A5A, 3'd0, 0};
        vecs[9] = '{32, 0, 24'h0, 24'h0, 24'h3E3E3E, 24'h0C0C0C, 3'd0, 0};

        reset_n                = 1'b0;
        AUD_BCLK               = 1'b1;
        AUD_DACLRCK            = 1'b1;
        bus_if.write           = 1'b0;
        bus_if.writedata_left  = {DW{1'b0}};
        bus_if.writedata_right = {DW{1'b0}};
        repeat (5) @(negedge CLOCK_50);
        check("reset_dacdat", 32'(AUD_DACDAT), 32'(0));
        check("reset_underflow", 32'(underflow), 32'(0));
        check("reset_count", 32'(bus_if.fifo_count), 32'(0));
        check("reset_ready", 32'(bus_if.write_ready), 32'(1));
        reset_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        for (int k = 0; k < 4; k++) bclk_pulse(1'b1, 1'b0, {DW{1'b0}}, {DW{1'b0}}, b, c);

        // Fill: write held high for six cycles, only four pairs fit
        @(negedge CLOCK_50);
        bus_if.write = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus_if.writedata_left  = fill_l[k];
            bus_if.writedata_right = fill_r[k];
            @(negedge CLOCK_50);
            check($sformatf("fill%0d_count", k + 1), 32'(bus_if.fifo_count),
                  32'((k + 1 < DEPTH) ? k + 1 : DEPTH));
            check($sformatf("fill%0d_ready", k + 1), 32'(bus_if.write_ready),
                  32'((k + 1 < DEPTH) ? 1 : 0));
        end
        bus_if.write = 1'b0;

        for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);

        // Reset in the middle of the left channel, while bit 14 (a one) is on the line
        push_pair(24'hFFFFFF, 24'hFFFFFF, 1);
        push_pair(24'h123123, 24'h321321, 2);
        for (int k = 0; k <= 10; k++) bclk_pulse(1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, b, c);
        check("midreset_dac_before", 32'(AUD_DACDAT), 32'(1));
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset_dac", 32'(AUD_DACDAT), 32'(0));
        check("midreset_count", 32'(bus_if.fifo_count), 32'(0));
        check("midreset_ready", 32'(bus_if.write_ready), 32'(1));
        AUD_DACLRCK = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);

        push_pair(vecs[9].el, vecs[9].er, 1);
        any = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bclk_pulse(1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, b, c);
            any = any | b;
        end
        for (int k = 0; k < 30; k++) begin
            bclk_pulse(1'b1, 1'b0, {DW{1'b0}}, {DW{1'b0}}, b, c);
            any = any | b;
        end
        check("postreset_quiet", 32'(any), 32'(0));
        check("postreset_no_pop", 32'(bus_if.fifo_count), 32'(1));
        run_frame(9, vecs[9]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
